// File: rtl/sd_resp_pkg.sv
// Shared types and constants for the sector-level SD block responder.
//   SECTOR_BYTES / IDX_W : sector size and byte-index width
//   sd_op_e              : latched request kind
//   sd_state_e           : responder FSM states
package sd_resp_pkg;

  localparam int unsigned SECTOR_BYTES = 512;
  localparam int unsigned IDX_W        = 9;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SECTOR_BYTES - 1);

  typedef enum logic {
    SD_OP_RD = 1'b0,
    SD_OP_WR = 1'b1
  } sd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_REQ    = 3'd1,
    ST_RD_PUSH   = 3'd2,
    ST_WR_ADDR   = 3'd3,
    ST_WR_SAMPLE = 3'd4,
    ST_WR_REQ    = 3'd5,
    ST_DONE      = 3'd6,
    ST_GAP       = 3'd7
  } sd_state_e;

  // States during which the sector handshake (sd_ack) is held high.
  function automatic logic in_transfer(input sd_state_e s);
    return s inside {ST_RD_REQ, ST_RD_PUSH, ST_WR_ADDR, ST_WR_SAMPLE, ST_WR_REQ};
  endfunction

endpackage

// File: rtl/sd_block_responder.sv
// Sector-level SD request/acknowledge responder backed by a byte store.
// Reads stream 512 bytes store -> requester buffer; writes pull 512 bytes
// requester buffer -> store.
//
// Parameters:
//   STORE_AW : store byte address width (2**(STORE_AW-9) sectors)
//   ACK_GAP  : idle cycles in GAP after sd_ack falls (>= 1)
// Ports:
//   clk_sys, RESET_n                   : clock, async active-low reset
//   sd_lba, sd_rd, sd_wr, sd_ack       : sector request handshake
//   sd_buff_addr/dout/din, sd_buff_wr  : requester sector buffer (sync RAM)
//   st_addr, st_rd, st_wr, st_din,
//   st_dout, st_ready                  : backing byte store
//   sd_err                             : out-of-range sector pulse (option)
// Optional feature macro: SD_RANGE_CHECK_EN
//   defined   -> lba beyond the store is flagged, store untouched, reads give 0
//   undefined -> lba upper bits are truncated (sectors alias)
module sd_block_responder
  import sd_resp_pkg::*;
#(
  parameter int unsigned STORE_AW = 13,
  parameter int unsigned ACK_GAP  = 2
) (
  input  logic                clk_sys,
  input  logic                RESET_n,
  input  logic [31:0]         sd_lba,
  input  logic                sd_rd,
  input  logic                sd_wr,
  output logic                sd_ack,
  output logic [IDX_W-1:0]    sd_buff_addr,
  output logic [7:0]          sd_buff_dout,
  input  logic [7:0]          sd_buff_din,
  output logic                sd_buff_wr,
`ifdef SD_RANGE_CHECK_EN
  output logic                sd_err,
`endif
  output logic [STORE_AW-1:0] st_addr,
  output logic                st_rd,
  output logic                st_wr,
  output logic [7:0]          st_din,
  input  logic [7:0]          st_dout,
  input  logic                st_ready
);

  localparam int unsigned SEC_W = STORE_AW - IDX_W;
  localparam int unsigned GAP_W = (ACK_GAP > 1) ? $clog2(ACK_GAP) : 1;

  sd_state_e          r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [SEC_W-1:0]   r_lba, w_lba_nxt;
  logic               r_ack, w_ack_nxt;
  logic               r_buff_wr, w_buff_wr_nxt;
  logic [7:0]         r_buff_dout, w_dout_nxt;
  logic               r_st_rd, w_st_rd_nxt;
  logic               r_st_wr, w_st_wr_nxt;
  logic [7:0]         r_st_din, w_st_din_nxt;
  logic [GAP_W-1:0]   r_gap_cnt, w_gap_nxt;
  logic               w_oor_cur, w_oor_nxt;
  logic               w_last;
  sd_op_e             w_op;

`ifdef SD_RANGE_CHECK_EN
  logic               r_oor;
  logic               r_err, w_err_nxt;
  assign w_oor_cur = r_oor;
  assign sd_err    = r_err;
`else
  // Upper lba bits are deliberately dropped: sectors alias modulo capacity.
  logic               w_unused_lba;
  assign w_oor_cur    = 1'b0;
  assign w_unused_lba = ^sd_lba[31:SEC_W];
`endif

  assign w_last = (r_idx == IDX_LAST);

  // Next-state and next-register values.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_lba_nxt    = r_lba;
    w_dout_nxt   = r_buff_dout;
    w_st_din_nxt = r_st_din;
    w_gap_nxt    = r_gap_cnt;
    w_oor_nxt    = w_oor_cur;
    w_op         = SD_OP_RD;

    case (r_state)
      ST_IDLE: begin
        if (sd_rd || sd_wr) begin
          w_op      = sd_rd ? SD_OP_RD : SD_OP_WR;
          w_lba_nxt = sd_lba[SEC_W-1:0];
          w_idx_nxt = '0;
`ifdef SD_RANGE_CHECK_EN
          w_oor_nxt = ((sd_lba >> SEC_W) != 32'd0);
`endif
          w_state_nxt = (w_op == SD_OP_RD) ? ST_RD_REQ : ST_WR_ADDR;
        end
      end

      // Out-of-range sectors skip the store and deliver zeros.
      ST_RD_REQ: begin
        if (w_oor_cur) begin
          w_dout_nxt  = 8'h00;
          w_state_nxt = ST_RD_PUSH;
        end else if (st_ready && r_st_rd) begin
          w_dout_nxt  = st_dout;
          w_state_nxt = ST_RD_PUSH;
        end
      end

      ST_RD_PUSH: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_idx_nxt   = r_idx + IDX_W'(1);
          w_state_nxt = ST_RD_REQ;
        end
      end

      // Address is presented here; the sync RAM answers one edge later.
      ST_WR_ADDR: w_state_nxt = ST_WR_SAMPLE;

      ST_WR_SAMPLE: begin
        w_st_din_nxt = sd_buff_din;
        w_state_nxt  = ST_WR_REQ;
      end

      ST_WR_REQ: begin
        if (w_oor_cur || (st_ready && r_st_wr)) begin
          if (w_last) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_state_nxt = ST_WR_ADDR;
          end
        end
      end

      ST_DONE: begin
        w_gap_nxt   = GAP_W'(ACK_GAP - 1);
        w_state_nxt = ST_GAP;
      end

      ST_GAP: begin
        if (r_gap_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_gap_nxt = r_gap_cnt - GAP_W'(1);
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase

    // Outputs are registered from the state being entered.
    w_ack_nxt     = in_transfer(w_state_nxt);
    w_buff_wr_nxt = (w_state_nxt == ST_RD_PUSH);
    w_st_rd_nxt   = (w_state_nxt == ST_RD_REQ) && !w_oor_nxt;
    w_st_wr_nxt   = (w_state_nxt == ST_WR_REQ) && !w_oor_nxt;
`ifdef SD_RANGE_CHECK_EN
    w_err_nxt     = (w_state_nxt == ST_DONE) && w_oor_cur;
`endif
  end

  // State and output registers.
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_lba       <= '0;
      r_ack       <= 1'b0;
      r_buff_wr   <= 1'b0;
      r_buff_dout <= 8'h00;
      r_st_rd     <= 1'b0;
      r_st_wr     <= 1'b0;
      r_st_din    <= 8'h00;
      r_gap_cnt   <= '0;
`ifdef SD_RANGE_CHECK_EN
      r_oor       <= 1'b0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_lba       <= w_lba_nxt;
      r_ack       <= w_ack_nxt;
      r_buff_wr   <= w_buff_wr_nxt;
      r_buff_dout <= w_dout_nxt;
      r_st_rd     <= w_st_rd_nxt;
      r_st_wr     <= w_st_wr_nxt;
      r_st_din    <= w_st_din_nxt;
      r_gap_cnt   <= w_gap_nxt;
`ifdef SD_RANGE_CHECK_EN
      r_oor       <= w_oor_nxt;
      r_err       <= w_err_nxt;
`endif
    end
  end

  assign sd_ack       = r_ack;
  assign sd_buff_addr = r_idx;
  assign sd_buff_dout = r_buff_dout;
  assign sd_buff_wr   = r_buff_wr;
  assign st_addr      = {r_lba, r_idx};
  assign st_rd        = r_st_rd;
  assign st_wr        = r_st_wr;
  assign st_din       = r_st_din;

endmodule

// File: tb/tb_sd_block_responder.sv
// Scoreboard bench for sd_block_responder: a sector-level reference model
// pushes expected buffer strobes and store accesses; a monitor pops them.
module tb_sd_block_responder;

  localparam int unsigned STORE_AW  = 13;
  localparam int unsigned ACK_GAP   = 2;
  localparam int unsigned SECTORS   = 1 << (STORE_AW - 9);
  localparam int unsigned SEC_BYTES = 512;
  localparam int unsigned ST_BYTES  = SECTORS * SEC_BYTES;
`ifdef SD_RANGE_CHECK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  logic                clk_sys;
  logic                RESET_n;
  logic [31:0]         sd_lba;
  logic                sd_rd, sd_wr, sd_ack;
  logic [8:0]          sd_buff_addr;
  logic [7:0]          sd_buff_dout, sd_buff_din;
  logic                sd_buff_wr;
  logic [STORE_AW-1:0] st_addr;
  logic                st_rd, st_wr;
  logic [7:0]          st_din, st_dout;
  logic                st_ready;
`ifdef SD_RANGE_CHECK_EN
  logic                sd_err;
`endif

  sd_block_responder #(.STORE_AW(STORE_AW), .ACK_GAP(ACK_GAP)) dut (
    .clk_sys      (clk_sys),
    .RESET_n      (RESET_n),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_dout (sd_buff_dout),
    .sd_buff_din  (sd_buff_din),
    .sd_buff_wr   (sd_buff_wr),
`ifdef SD_RANGE_CHECK_EN
    .sd_err       (sd_err),
`endif
    .st_addr      (st_addr),
    .st_rd        (st_rd),
    .st_wr        (st_wr),
    .st_din       (st_din),
    .st_dout      (st_dout),
    .st_ready     (st_ready)
  );

  typedef struct { logic [8:0] addr; logic [7:0] data; } buf_exp_t;
  typedef struct { bit wr; logic [STORE_AW-1:0] addr; logic [7:0] data; } st_exp_t;

  buf_exp_t   buf_q[$];
  st_exp_t    st_q[$];
  buf_exp_t   mon_be;
  st_exp_t    mon_se;

  int         n_checks;
  int         n_errors;
  int         err_pulses;
  int         base_lat;
  int         stall_extra;
  logic [8:0] stall_byte;
  int         wait_cnt;
  logic       prev_rd_pend, prev_wr_pend;

  logic [7:0] mem    [ST_BYTES];
  logic [7:0] refmem [ST_BYTES];
  logic [7:0] req_ram[SEC_BYTES];

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requester sector buffer: synchronous-read RAM.
  always @(posedge clk_sys) sd_buff_din <= req_ram[sd_buff_addr];

  // Backing store: answers after base_lat extra cycles, stall_extra more on stall_byte.
  always @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      st_ready <= 1'b0;
      st_dout  <= 8'h00;
      wait_cnt <= 0;
    end else begin
      st_ready <= 1'b0;
      if ((st_rd || st_wr) && !st_ready) begin
        if (wait_cnt >= ((st_addr[8:0] == stall_byte) ? base_lat + stall_extra : base_lat)) begin
          st_ready <= 1'b1;
          wait_cnt <= 0;
          if (st_wr) mem[st_addr] <= st_din;
          else       st_dout      <= mem[st_addr];
        end else begin
          wait_cnt <= wait_cnt + 1;
        end
      end
    end
  end

  // Monitor: pops expectations on every store completion and buffer strobe.
  always @(negedge clk_sys) begin
    if (!RESET_n) begin
      prev_rd_pend = 1'b0;
      prev_wr_pend = 1'b0;
    end else begin
      if (prev_rd_pend) chk("st_rd_held", 32'(st_rd), 32'd1);
      if (prev_wr_pend) chk("st_wr_held", 32'(st_wr), 32'd1);
      prev_rd_pend = st_rd && !st_ready;
      prev_wr_pend = st_wr && !st_ready;
      if (st_ready && (st_rd || st_wr)) begin
        chk("st_access_expected", 32'(st_q.size() > 0), 32'd1);
        if (st_q.size() > 0) begin
          mon_se = st_q.pop_front();
          chk("st_op_is_wr", 32'(st_wr), 32'(mon_se.wr));
          chk("st_addr", 32'(st_addr), 32'(mon_se.addr));
          if (mon_se.wr) chk("st_din", 32'(st_din), 32'(mon_se.data));
        end
      end
      if (sd_buff_wr) begin
        chk("buff_wr_expected", 32'(buf_q.size() > 0), 32'd1);
        chk("buff_wr_inside_ack", 32'(sd_ack), 32'd1);
        if (buf_q.size() > 0) begin
          mon_be = buf_q.pop_front();
          chk("buff_addr", 32'(sd_buff_addr), 32'(mon_be.addr));
          chk("buff_dout", 32'(sd_buff_dout), 32'(mon_be.data));
        end
      end
`ifdef SD_RANGE_CHECK_EN
      if (sd_err) err_pulses++;
`endif
    end
  end

  // Reference model for one sector, then drive the level handshake.
  task automatic xfer(input bit rd, input bit wr, input int unsigned lba, output int n_ack);
    bit          oor;
    int unsigned base;
    oor  = RANGE_CHK && (lba >= SECTORS);
    base = (lba % SECTORS) * SEC_BYTES;
    for (int i = 0; i < int'(SEC_BYTES); i++) begin
      if (rd) begin
        buf_q.push_back('{addr: 9'(i), data: oor ? 8'h00 : refmem[base + i]});
        if (!oor) st_q.push_back('{wr: 1'b0, addr: STORE_AW'(base + i), data: 8'h00});
      end else if (!oor) begin
        st_q.push_back('{wr: 1'b1, addr: STORE_AW'(base + i), data: req_ram[i]});
        refmem[base + i] = req_ram[i];
      end
    end
    err_pulses = 0;
    sd_lba = lba;
    sd_rd  = rd;
    sd_wr  = wr;
    n_ack  = 0;
    for (int c = 0; c < 64; c++) begin
      @(posedge clk_sys);
      n_ack++;
      @(negedge clk_sys);
      if (sd_ack) break;
    end
    chk("ack_rise", 32'(sd_ack), 32'd1);
    sd_rd = 1'b0;
    sd_wr = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk_sys);
      if (!sd_ack) break;
    end
    chk("ack_fall", 32'(sd_ack), 32'd0);
    #1;
    chk("buf_q_drained", 32'(buf_q.size()), 32'd0);
    chk("st_q_drained", 32'(st_q.size()), 32'd0);
`ifdef SD_RANGE_CHECK_EN
    chk("sd_err_pulses", 32'(err_pulses), 32'(oor));
`endif
    buf_q.delete();
    st_q.delete();
  endtask

  // Start a read of lba 0 and assert reset while byte 100 is being strobed.
  task automatic reset_mid_read();
    for (int i = 0; i < int'(SEC_BYTES); i++) begin
      buf_q.push_back('{addr: 9'(i), data: refmem[i]});
      st_q.push_back('{wr: 1'b0, addr: STORE_AW'(i), data: 8'h00});
    end
    sd_lba = 32'd0;
    sd_rd  = 1'b1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk_sys);
      if (sd_ack) break;
    end
    sd_rd = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk_sys);
      if (sd_buff_wr && sd_buff_addr == 9'd100) break;
    end
    chk("pre_reset_strobe_100", 32'(sd_buff_wr && sd_buff_addr == 9'd100), 32'd1);
    #2 RESET_n = 1'b0;
    #1;
    chk("async_rst_ack", 32'(sd_ack), 32'd0);
    chk("async_rst_buff_wr", 32'(sd_buff_wr), 32'd0);
    chk("async_rst_st_rd", 32'(st_rd), 32'd0);
    chk("async_rst_buff_addr", 32'(sd_buff_addr), 32'd0);
    chk("async_rst_st_addr", 32'(st_addr), 32'd0);
    buf_q.delete();
    st_q.delete();
    repeat (2) @(negedge clk_sys);
    RESET_n = 1'b1;
    repeat (2) @(negedge clk_sys);
  endtask

  initial begin
    int          n;
    int          bad;
    bit          rd;
    int unsigned lba;

    n_checks    = 0;
    n_errors    = 0;
    err_pulses  = 0;
    RESET_n     = 1'b0;
    sd_lba      = 32'd0;
    sd_rd       = 1'b0;
    sd_wr       = 1'b0;
    base_lat    = 0;
    stall_extra = 0;
    stall_byte  = 9'd0;
    for (int i = 0; i < int'(ST_BYTES); i++) begin
      mem[i]    <= 8'(i);
      refmem[i]  = 8'(i);
    end
    for (int i = 0; i < int'(SEC_BYTES); i++) req_ram[i] = 8'h00;

    repeat (3) @(negedge clk_sys);
    chk("rst_ack", 32'(sd_ack), 32'd0);
    chk("rst_buff_wr", 32'(sd_buff_wr), 32'd0);
    chk("rst_st_rd", 32'(st_rd), 32'd0);
    chk("rst_st_wr", 32'(st_wr), 32'd0);
    chk("rst_buff_addr", 32'(sd_buff_addr), 32'd0);
    chk("rst_buff_dout", 32'(sd_buff_dout), 32'd0);
    chk("rst_st_addr", 32'(st_addr), 32'd0);
    chk("rst_st_din", 32'(st_din), 32'd0);
`ifdef SD_RANGE_CHECK_EN
    chk("rst_sd_err", 32'(sd_err), 32'd0);
`endif
    RESET_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    reset_mid_read();

    xfer(1'b1, 1'b0, 32'd0, n);
    chk("ack_latency_from_idle", 32'(n), 32'd1);
    xfer(1'b1, 1'b0, 32'd3, n);
    chk("ack_latency_after_gap", 32'(n), 32'(ACK_GAP + 2));

    for (int i = 0; i < int'(SEC_BYTES); i++) req_ram[i] = 8'hA5 ^ 8'(i);
    repeat (3) @(negedge clk_sys);
    xfer(1'b0, 1'b1, 32'd15, n);

    xfer(1'b1, 1'b1, 32'd2, n);

    stall_byte  = 9'd255;
    stall_extra = 7;
    xfer(1'b1, 1'b0, $urandom_range(0, SECTORS - 1), n);
    stall_extra = 0;

    xfer(1'b1, 1'b0, 32'd16, n);
    xfer(1'b1, 1'b0, 32'd15, n);

    for (int t = 0; t < 6; t++) begin
      base_lat = int'($urandom_range(0, 2));
      rd       = 1'($urandom_range(0, 1));
      lba      = $urandom_range(0, SECTORS + 3);
      if (!rd) for (int i = 0; i < int'(SEC_BYTES); i++) req_ram[i] = 8'($urandom);
      repeat (int'($urandom_range(0, 4))) @(negedge clk_sys);
      xfer(rd, !rd, lba, n);
    end

    repeat (2) @(negedge clk_sys);
    bad = 0;
    for (int i = 0; i < int'(ST_BYTES); i++) if (mem[i] !== refmem[i]) bad++;
    chk("store_image", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
